// File: rtl/loader_pkg.sv
// Shared types and defaults for the byte-stream program loader.
// Holds the FSM state encoding and the bus width defaults.
package loader_pkg;

   localparam int LOADER_ADDR_W         = 12;
   localparam int LOADER_INSTR_W        = 19;
   localparam int LOADER_BYTES_PER_WORD = 3;
   localparam int LOADER_LEN_W          = 12;

   typedef enum logic [3:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_B0,
      S_B1,
      S_B2,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } loader_state_t;

   // States in which the loader offers byte_ready.
   function automatic logic is_accepting(input loader_state_t st);
      return (st == S_LEN_HI) || (st == S_LEN_LO) || (st == S_B0) ||
             (st == S_B1) || (st == S_B2) || (st == S_CHK);
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Load-stream input and instruction-memory write/status bundle.
// The master side is the loader, the slave side is the stream source / memory.
interface program_loader_if
   import loader_pkg::*;
#(
   parameter int ADDR_W  = LOADER_ADDR_W,
   parameter int INSTR_W = LOADER_INSTR_W
);
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic               im_write_en;
   logic [ADDR_W-1:0]  im_write_addr;
   logic [INSTR_W-1:0] im_write_data;
   logic               core_rst;
   logic               load_done;
   logic               load_error;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, im_write_en, im_write_addr, im_write_data,
             core_rst, load_done, load_error
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, im_write_en, im_write_addr, im_write_data,
             core_rst, load_done, load_error
   );
endinterface

// File: rtl/instr_assembler.sv
// Shifts bytes in MSB-first; after three loads the low WORD_W bits hold
// {B0[2:0], B1, B2}, so the unused upper bits of B0 fall off the top.
module instr_assembler
   import loader_pkg::*;
#(
   parameter int WORD_W = LOADER_INSTR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word
);
   logic [WORD_W-1:0] word_q;
   logic [WORD_W-1:0] word_d;

   always_comb begin
      word_d = word_q;
      if (load_en) begin
         word_d = {word_q[WORD_W-9:0], byte_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word = word_q;
endmodule

// File: rtl/program_loader.sv
// Byte-stream loader: length header, 3-byte instruction words, XOR checksum.
// Holds the core in reset until a complete image with a good checksum arrives.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W  = LOADER_ADDR_W,
   parameter int INSTR_W = LOADER_INSTR_W
) (
   input logic               clk,
   input logic               rst,
   program_loader_if.master  bus
);
   loader_state_t           state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [LOADER_LEN_W-1:0] word_cnt_q, word_cnt_d;
   logic [LOADER_LEN_W-1:0] len_q, len_d;
   logic [7:0]              xor_q, xor_d;
   logic                    byte_ready_q, byte_ready_d;
   logic                    write_en_q, write_en_d;
   logic                    core_rst_q, core_rst_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    xfer;
   logic                    asm_en;
   logic [INSTR_W-1:0]      asm_word;

   instr_assembler #(.WORD_W(INSTR_W)) u_asm (
      .clk     (clk),
      .rst     (rst),
      .load_en (asm_en),
      .byte_in (bus.byte_in),
      .word    (asm_word)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      xor_d      = xor_q;
      asm_en     = 1'b0;
      xfer       = bus.byte_valid && byte_ready_q;

      case (state_q)
         S_LEN_HI: if (xfer) begin
            len_d[11:8] = bus.byte_in[3:0];
            xor_d       = xor_q ^ bus.byte_in;
            state_d     = S_LEN_LO;
         end
         S_LEN_LO: if (xfer) begin
            len_d[7:0] = bus.byte_in;
            xor_d      = xor_q ^ bus.byte_in;
            state_d    = ({len_q[11:8], bus.byte_in} == '0) ? S_CHK : S_B0;
         end
         S_B0, S_B1, S_B2: if (xfer) begin
            asm_en  = 1'b1;
            xor_d   = xor_q ^ bus.byte_in;
            state_d = (state_q == S_B0) ? S_B1 :
                      (state_q == S_B1) ? S_B2 : S_WRITE;
         end
         S_WRITE: begin
            addr_d     = addr_q + ADDR_W'(1);
            word_cnt_d = word_cnt_q + LOADER_LEN_W'(1);
            state_d    = (word_cnt_d == len_q) ? S_CHK : S_B0;
         end
         S_CHK: if (xfer) begin
            state_d = (bus.byte_in == xor_q) ? S_DONE : S_ERR;
         end
         default: state_d = state_q;
      endcase

      // Outputs are registered from the next state so they line up with it.
      byte_ready_d = is_accepting(state_d);
      write_en_d   = (state_d == S_WRITE);
      core_rst_d   = (state_d != S_DONE);
      done_d       = (state_d == S_DONE);
      err_d        = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_LEN_HI;
         addr_q       <= '0;
         word_cnt_q   <= '0;
         len_q        <= '0;
         xor_q        <= '0;
         byte_ready_q <= 1'b1;
         write_en_q   <= 1'b0;
         core_rst_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         word_cnt_q   <= word_cnt_d;
         len_q        <= len_d;
         xor_q        <= xor_d;
         byte_ready_q <= byte_ready_d;
         write_en_q   <= write_en_d;
         core_rst_q   <= core_rst_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Reset arriving during S_WRITE must suppress that cycle's strobe.
   assign bus.im_write_en   = write_en_q & ~rst;
   assign bus.im_write_addr = addr_q;
   assign bus.im_write_data = asm_word;
   assign bus.byte_ready    = byte_ready_q;
   assign bus.core_rst      = core_rst_q;
   assign bus.load_done     = done_q;
   assign bus.load_error    = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: length/word/checksum streams, stalls,
// mid-load resets and post-completion behaviour.
module tb_program_loader;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   logic [11:0] wr_addr[$];
   logic [18:0] wr_data[$];

   program_loader_if bus ();

   program_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-22s observed %0h expected %0h", tag, obs, exp);
   endtask

   // Capture every write strobe; the loader must not offer a byte while writing.
   always @(negedge clk) begin
      if (bus.im_write_en === 1'b1) begin
         wr_addr.push_back(bus.im_write_addr);
         wr_data.push_back(bus.im_write_data);
         n_cmp++;
         assert (bus.byte_ready === 1'b0) else begin
            n_fail++;
            $error("FAIL ready_in_write: observed %b expected 0", bus.byte_ready);
         end
         $display("write addr %0h data %05h", bus.im_write_addr, bus.im_write_data);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int idle);
      int waited;
      bus.byte_valid = 1'b0;
      repeat (idle) begin
         @(posedge clk);
         #1;
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      waited = 0;
      while (bus.byte_ready !== 1'b1 && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (waited >= 20) begin
         check("ready_timeout", 32'(bus.byte_ready), 32'd1);
      end else begin
         @(posedge clk);
         #1;
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.byte_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   logic [7:0] img2[9];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      img2 = '{8'h00, 8'h02, 8'h05, 8'hA1, 8'hB2, 8'h00, 8'h00, 8'h01, 8'h15};
      repeat (3) @(posedge clk);
      #1;
      check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
      check("rst_write_en",   32'(bus.im_write_en), 32'd0);
      check("rst_core_rst",   32'(bus.core_rst), 32'd1);
      check("rst_load_done",  32'(bus.load_done), 32'd0);
      check("rst_load_error", 32'(bus.load_error), 32'd0);
      rst = 1'b0;

      // N=0: header and checksum only
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("n0_done",     32'(bus.load_done), 32'd1);
      check("n0_core_rst", 32'(bus.core_rst), 32'd0);
      check("n0_writes",   32'(wr_addr.size()), 32'd0);

      // N=2 full rate, good checksum
      do_reset();
      for (int i = 0; i < 9; i++) send_byte(img2[i], 0);
      check("n2_done",     32'(bus.load_done), 32'd1);
      check("n2_core_rst", 32'(bus.core_rst), 32'd0);
      check("n2_writes",   32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("n2_addr0", 32'(wr_addr[0]), 32'h0);
         check("n2_data0", 32'(wr_data[0]), 32'h5A1B2);
         check("n2_addr1", 32'(wr_addr[1]), 32'h1);
         check("n2_data1", 32'(wr_data[1]), 32'h00001);
      end
      // extra bytes after completion are never accepted
      bus.byte_in    = 8'hAA;
      bus.byte_valid = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("done_no_ready", 32'(bus.byte_ready), 32'd0);
      check("done_holds",    32'(bus.load_done), 32'd1);
      check("done_no_write", 32'(wr_addr.size()), 32'd2);
      bus.byte_valid = 1'b0;

      // bad checksum
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(img2[i], 0);
      send_byte(8'h16, 0);
      check("bad_error",    32'(bus.load_error), 32'd1);
      check("bad_done",     32'(bus.load_done), 32'd0);
      check("bad_core_rst", 32'(bus.core_rst), 32'd1);
      check("bad_writes",   32'(wr_addr.size()), 32'd2);

      // throttled valid with a 5-cycle gap mid-word
      do_reset();
      for (int i = 0; i < 9; i++)
         send_byte(img2[i], (i == 3) ? 5 : int'($urandom_range(0, 2)));
      check("thr_done",   32'(bus.load_done), 32'd1);
      check("thr_writes", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("thr_data0", 32'(wr_data[0]), 32'h5A1B2);
         check("thr_data1", 32'(wr_data[1]), 32'h00001);
         check("thr_addr1", 32'(wr_addr[1]), 32'h1);
      end

      // reset while in S_WRITE: no strobe that cycle
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      rst = 1'b1;
      #1;
      check("rst_in_write_en", 32'(bus.im_write_en), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_write_cnt", 32'(wr_addr.size()), 32'd0);
      wr_addr.delete();
      wr_data.delete();

      // reset during S_B1 of word 1 of a 3-word image
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      check("abort_pre_writes", 32'(wr_addr.size()), 32'd1);
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hFD, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hDA, 0);
      check("abort_done",   32'(bus.load_done), 32'd1);
      check("abort_writes", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         check("abort_addr", 32'(wr_addr[0]), 32'h0);
         check("abort_data", 32'(wr_data[0]), 32'h51234);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
